// File: rtl/dmem_bus_responder.sv
// dmem_bus_responder
// Memory-side responder for the CPU data-memory port. Turns byte/half/word
// load and store requests into accesses on a word-wide synchronous SRAM
// without byte enables. Sub-word stores are performed as read-modify-write.
//
// Timing model (all outputs registered):
//  - SRAM reads are issued on entry to RD / RMW_RD, so the read word is on
//    ram_rdata while the FSM sits in RDCAP / RMW_WR.
//  - SRAM writes are issued together with ack on the edge that leaves
//    WR / RMW_WR. The SRAM commits the write at the edge that closes the ack
//    cycle, before any later read can be issued.
//  - Latency counted in edges from the accepting edge: word store and error
//    ack 1 edge later, loads and sub-word stores 2 edges later.
module dmem_bus_responder #(
  parameter int ADDR_W = 11,
  parameter int RAM_AW = ADDR_W - 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_ena,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        data_w,
  input  logic              data_sign,
  input  logic [31:0]       req_wdata,
  output logic [31:0]       rdata,
  output logic              ack,
  output logic              err,
  output logic              busy,
  output logic              ram_ce,
  output logic              ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  localparam logic [2:0] W_BYTE = 3'b001;
  localparam logic [2:0] W_HALF = 3'b010;
  localparam logic [2:0] W_WORD = 3'b100;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD,
    S_RDCAP,
    S_RMW_RD,
    S_RMW_WR,
    S_ERR
  } state_t;

  state_t      state;
  logic [1:0]  lat_lane;
  logic [2:0]  lat_w;
  logic        lat_sign;
  logic [31:0] lat_wdata;
  logic        req_bad;

  // Pick the addressed lane out of a read word and extend it to 32 bits.
  function automatic logic [31:0] load_fmt(input logic [31:0] word,
                                           input logic [1:0]  lane,
                                           input logic [2:0]  w,
                                           input logic        sgn);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (w)
      W_BYTE:  res = {{24{sgn & b[7]}}, b};
      W_HALF:  res = {{16{sgn & h[15]}}, h};
      default: res = word;
    endcase
    return res;
  endfunction

  // Overlay the low store bits onto the addressed lane(s) of the old word.
  function automatic logic [31:0] merge(input logic [31:0] word,
                                        input logic [31:0] wd,
                                        input logic [1:0]  lane,
                                        input logic [2:0]  w);
    logic [31:0] res;
    res = word;
    if (w == W_HALF) begin
      if (lane[1]) res[31:16] = wd[15:0];
      else         res[15:0]  = wd[15:0];
    end else begin
      case (lane)
        2'd0:    res[7:0]   = wd[7:0];
        2'd1:    res[15:8]  = wd[7:0];
        2'd2:    res[23:16] = wd[7:0];
        default: res[31:24] = wd[7:0];
      endcase
    end
    return res;
  endfunction

  // Flag requests that are misaligned for their width or use an invalid width code.
  always_comb begin
    // NOTE: req_bad gets a value before the case so no path leaves it unassigned (no latch).
    req_bad = 1'b1;
    case (data_w)
      W_BYTE:  req_bad = 1'b0;
      W_HALF:  req_bad = req_addr[0];
      W_WORD:  req_bad = |req_addr[1:0];
      default: req_bad = 1'b1;
    endcase
  end

  // Request FSM with registered SRAM controls, ack/err and load data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      lat_lane  <= '0;
      lat_w     <= '0;
      lat_sign  <= 1'b0;
      lat_wdata <= '0;
      rdata     <= '0;
      ack       <= 1'b0;
      err       <= 1'b0;
      busy      <= 1'b0;
      ram_ce    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every branch sees pre-edge values.
      ram_ce <= 1'b0;
      ram_we <= 1'b0;
      ack    <= 1'b0;
      err    <= 1'b0;
      unique case (state)
        S_IDLE: begin
          busy <= req_ena;
          if (req_ena) begin
            lat_lane  <= req_addr[1:0];
            lat_w     <= data_w;
            lat_sign  <= data_sign;
            lat_wdata <= req_wdata;
            if (req_bad) begin
              state <= S_ERR;
            end else begin
              ram_addr <= req_addr[ADDR_W-1:2];
              if (req_we && data_w == W_WORD) begin
                state <= S_WR;
              end else if (req_we) begin
                state  <= S_RMW_RD;
                ram_ce <= 1'b1;
              end else begin
                state  <= S_RD;
                ram_ce <= 1'b1;
              end
            end
          end
        end
        S_WR: begin
          ram_ce    <= 1'b1;
          ram_we    <= 1'b1;
          ram_wdata <= lat_wdata;
          ack       <= 1'b1;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end
        S_RD: begin
          state <= S_RDCAP;
        end
        S_RDCAP: begin
          rdata <= load_fmt(ram_rdata, lat_lane, lat_w, lat_sign);
          ack   <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        S_RMW_RD: begin
          state <= S_RMW_WR;
        end
        S_RMW_WR: begin
          ram_ce    <= 1'b1;
          ram_we    <= 1'b1;
          ram_wdata <= merge(ram_rdata, lat_wdata, lat_lane, lat_w);
          ack       <= 1'b1;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end
        S_ERR: begin
          ack   <= 1'b1;
          err   <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_bus_responder.sv
// Scoreboard bench for dmem_bus_responder: a byte-addressed reference memory
// predicts every response; a monitor checks acks, SRAM traffic and busy.
module tb_dmem_bus_responder;

  localparam int ADDR_W = 11;
  localparam int RAM_AW = 9;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_ena, req_we, data_sign;
  logic [ADDR_W-1:0] req_addr;
  logic [2:0]        data_w;
  logic [31:0]       req_wdata;
  logic [31:0]       rdata;
  logic              ack, err, busy, ram_ce, ram_we;
  logic [RAM_AW-1:0] ram_addr;
  logic [31:0]       ram_wdata, ram_rdata;

  always #5 clk = ~clk;

  dmem_bus_responder #(.ADDR_W(ADDR_W), .RAM_AW(RAM_AW)) dut (
    .clk(clk), .rst(rst_n), .req_ena(req_ena), .req_we(req_we),
    .req_addr(req_addr), .data_w(data_w), .data_sign(data_sign),
    .req_wdata(req_wdata), .rdata(rdata), .ack(ack), .err(err), .busy(busy),
    .ram_ce(ram_ce), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // Synchronous SRAM macro model.
  logic [31:0] sram [0:511];
  always @(posedge clk) begin
    if (ram_ce) begin
      if (ram_we) sram[ram_addr] <= ram_wdata;
      else        ram_rdata      <= sram[ram_addr];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic              err;
    logic [31:0]       rdata;
    int                acc_cyc;
    int                ack_cyc;
    int                ce_n;
    int                we_n;
    logic [RAM_AW-1:0] waddr;
    logic [31:0]       wword;
  } exp_t;

  exp_t        sbq[$];
  logic [7:0]  ref_mem [0:2047];
  logic [31:0] last_rdata = '0;

  function automatic int wbytes(input logic [2:0] w);
    case (w)
      3'b001:  return 1;
      3'b010:  return 2;
      3'b100:  return 4;
      default: return 0;
    endcase
  endfunction

  function automatic logic [31:0] ref_word(input int wi);
    return {ref_mem[4*wi+3], ref_mem[4*wi+2], ref_mem[4*wi+1], ref_mem[4*wi]};
  endfunction

  // Drive one request at a negedge, predict its response, wait for its ack.
  // Returns at the negedge where ack is seen, with req_ena still high.
  task automatic send(input logic we, input logic [ADDR_W-1:0] addr, input logic [2:0] w,
                      input logic sgn, input logic [31:0] wd);
    exp_t        e;
    int          n;
    int          a;
    int          k;
    bit          got;
    logic [63:0] v;
    n = wbytes(w);
    a = int'(addr);
    e.err     = (n == 0) ? 1'b1 : ((a % n) != 0);
    e.acc_cyc = cyc + 1;
    e.waddr   = addr[ADDR_W-1:2];
    e.ce_n    = 0;
    e.we_n    = 0;
    e.wword   = '0;
    if (e.err) begin
      e.rdata   = last_rdata;
      e.ack_cyc = cyc + 2;
    end else if (we) begin
      for (int i = 0; i < n; i++) ref_mem[a+i] = wd[8*i +: 8];
      e.wword   = ref_word(a / 4);
      e.ce_n    = (n == 4) ? 1 : 2;
      e.we_n    = 1;
      e.rdata   = last_rdata;
      e.ack_cyc = cyc + 1 + ((n == 4) ? 1 : 2);
    end else begin
      v = '0;
      for (int i = 0; i < n; i++) v = v | (64'(ref_mem[a+i]) << (8*i));
      if (sgn && v[8*n-1]) v = v | ~((64'd1 << (8*n)) - 64'd1);
      last_rdata = v[31:0];
      e.rdata    = v[31:0];
      e.ce_n     = 1;
      e.ack_cyc  = cyc + 3;
    end
    req_we    = we;
    req_addr  = addr;
    data_w    = w;
    data_sign = sgn;
    req_wdata = wd;
    req_ena   = 1'b1;
    sbq.push_back(e);
    k   = 0;
    got = 1'b0;
    while (k < 20 && !got) begin
      @(negedge clk);
      k++;
      got = ack;
    end
    if (!got) begin
      n_tests++;
      n_fail++;
      $display("FAIL ack_timeout: no ack within 20 cycles, one required");
      sbq.delete();
    end
  endtask

  task automatic idle();
    req_ena = 1'b0;
    @(negedge clk);
  endtask

  // Monitor: SRAM traffic, ack contents/timing, busy and ack spacing.
  int   ce_acc = 0, we_acc = 0, we_total = 0;
  bit   prev_ack = 1'b0;
  exp_t mon_e;
  always @(negedge clk) begin
    if (ram_ce && ram_we) we_total++;
    if (!rst_n) begin
      ce_acc   = 0;
      we_acc   = 0;
      prev_ack = 1'b0;
    end else begin
      if (ram_ce) begin
        ce_acc++;
        if (sbq.size() > 0) check("ram_addr", 32'(ram_addr), 32'(sbq[0].waddr));
      end
      if (ram_ce && ram_we) begin
        we_acc++;
        if (sbq.size() > 0) check("ram_wdata", ram_wdata, sbq[0].wword);
      end
      if (ack) begin
        if (prev_ack) check("ack_consecutive", 32'(ack), 32'd0);
        if (sbq.size() == 0) begin
          check("ack_unexpected", 32'(ack), 32'd0);
        end else begin
          mon_e = sbq.pop_front();
          check("err", 32'(err), 32'(mon_e.err));
          check("rdata", rdata, mon_e.rdata);
          check("ack_cycle", 32'(cyc), 32'(mon_e.ack_cyc));
          check("ce_count", 32'(ce_acc), 32'(mon_e.ce_n));
          check("we_count", 32'(we_acc), 32'(mon_e.we_n));
          check("busy_at_ack", 32'(busy), 32'd0);
        end
        ce_acc = 0;
        we_acc = 0;
      end else if (sbq.size() > 0 && cyc >= sbq[0].acc_cyc) begin
        check("busy_inflight", 32'(busy), 32'd1);
      end
      prev_ack = ack;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int we_snap;

  initial begin
    rst_n     = 1'b0;
    req_ena   = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    data_w    = 3'b100;
    data_sign = 1'b0;
    req_wdata = '0;
    for (int i = 0; i < 512; i++) begin
      sram[i] = $urandom;
      for (int b = 0; b < 4; b++) ref_mem[4*i+b] = sram[i][8*b +: 8];
    end
    repeat (2) @(negedge clk);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ram_ce", 32'(ram_ce), 32'd0);
    check("rst_ram_we", 32'(ram_we), 32'd0);
    check("rst_ram_addr", 32'(ram_addr), 32'd0);
    check("rst_ram_wdata", ram_wdata, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Word store then load.
    send(1'b1, 11'h010, 3'b100, 1'b0, 32'hDEADBEEF); idle();
    send(1'b0, 11'h010, 3'b100, 1'b0, 32'h0);
    check("ld_word", rdata, 32'hDEADBEEF);
    idle();
    // Byte store by read-modify-write.
    send(1'b1, 11'h010, 3'b100, 1'b0, 32'h11223344); idle();
    send(1'b1, 11'h012, 3'b001, 1'b1, 32'h123456AA); idle();
    check("rmw_word", sram[4], 32'h11AA3344);
    // Signed / unsigned sub-word loads.
    send(1'b0, 11'h012, 3'b001, 1'b1, 32'h0);
    check("ld_byte_s", rdata, 32'hFFFFFFAA);
    send(1'b0, 11'h012, 3'b001, 1'b0, 32'h0);
    check("ld_byte_u", rdata, 32'h000000AA);
    send(1'b0, 11'h012, 3'b010, 1'b1, 32'h0);
    check("ld_half_s", rdata, 32'h000011AA);
    idle();
    // Misaligned and invalid width.
    send(1'b0, 11'h013, 3'b010, 1'b1, 32'h0);
    check("err_half", 32'(err), 32'd1);
    check("err_rdata_held", rdata, 32'h000011AA);
    idle();
    send(1'b1, 11'h012, 3'b100, 1'b0, 32'hCAFEF00D); idle();
    send(1'b0, 11'h010, 3'b011, 1'b0, 32'h0); idle();
    check("err_no_write", sram[4], 32'h11AA3344);
    // Back-to-back loads with req_ena held.
    send(1'b0, 11'h010, 3'b100, 1'b0, 32'h0);
    send(1'b0, 11'h010, 3'b100, 1'b0, 32'h0);
    send(1'b0, 11'h010, 3'b100, 1'b0, 32'h0);
    idle();

    // Reset in the middle of a byte RMW.
    req_we = 1'b1; req_addr = 11'h020; data_w = 3'b001; data_sign = 1'b0;
    req_wdata = 32'h0000005A; req_ena = 1'b1;
    @(posedge clk);
    #2;
    rst_n   = 1'b0;
    req_ena = 1'b0;
    we_snap = we_total;
    #1;
    check("mid_rst_ram_ce", 32'(ram_ce), 32'd0);
    check("mid_rst_ram_we", 32'(ram_we), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_ack", 32'(ack), 32'd0);
    check("mid_rst_rdata", rdata, 32'd0);
    check("mid_rst_ram_wdata", ram_wdata, 32'd0);
    last_rdata = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("mid_rst_no_write", 32'(we_total - we_snap), 32'd0);
    check("mid_rst_word", sram[8], ref_word(8));
    send(1'b0, 11'h020, 3'b100, 1'b0, 32'h0); idle();

    // Randomized traffic over a small window so stores and loads collide.
    for (int t = 0; t < 300; t++) begin
      logic [2:0] wc;
      case ($urandom % 8)
        0, 3:    wc = 3'b001;
        1, 4:    wc = 3'b010;
        2, 5:    wc = 3'b100;
        6:       wc = 3'b011;
        default: wc = 3'b111;
      endcase
      send(1'($urandom % 2), 11'($urandom_range(0, 63)), wc, 1'($urandom % 2), $urandom);
      if (($urandom % 3) == 0) idle();
    end
    idle();
    repeat (5) @(negedge clk);
    check("sb_empty", 32'(sbq.size()), 32'd0);
    for (int i = 0; i < 512; i++) check("sram_final", sram[i], ref_word(i));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_bus_responder.md
Name: dmem_bus_responder

Overview:
- Memory-side responder for the CPU data-memory port: accepts the CPU's enable, write, address, width, sign and write-data request, and answers with formatted read data plus a completion pulse.
- Backs the port with a word-wide synchronous SRAM that has no byte enables.
- Sub-word stores are done as read-modify-write. The CPU stalls from request until ack.
- Sits between the CPU data port and the SRAM macro in the top-level dataflow.

Parameters:
- ADDR_W, 11, byte-address width of the request port.
- RAM_AW, ADDR_W-2, word-address width of the SRAM.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- req_ena  in  1  request valid; held stable by the CPU until ack.
- req_we  in  1  1=store, 0=load.
- req_addr  in  ADDR_W  byte address.
- data_w  in  3  width: 3'b001 byte, 3'b010 half, 3'b100 word; other codes are invalid.
- data_sign  in  1  loads only: 1=sign-extend, 0=zero-extend.
- req_wdata  in  32  store data; sub-word data sits in the low bits.
- rdata  out  32  formatted load data; valid in the ack cycle and held until the next load ack.
- ack  out  1  one-cycle completion pulse.
- err  out  1  valid with ack; 1 = misaligned or invalid width, no SRAM access performed.
- busy  out  1  high in any state other than IDLE.
- ram_ce  out  1  SRAM chip enable.
- ram_we  out  1  SRAM write enable; qualified by ram_ce.
- ram_addr  out  RAM_AW  SRAM word address (req_addr[ADDR_W-1:2]).
- ram_wdata  out  32  SRAM write data.
- ram_rdata  in  32  SRAM read data; valid the cycle after ram_ce=1 with ram_we=0.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE.
  - ram_ce, ram_we, ack, err and busy all 0.
  - ram_addr, ram_wdata and rdata all 0.
  - Reset mid-operation aborts the access: no SRAM write issues after reset asserts, and no ack is produced for the aborted request.
- All outputs are registered.
- States: IDLE, WR, RD, RDCAP, RMW_RD, RMW_WR, ERR.
- IDLE:
  - req_ena=1 latches addr, width, sign, we and wdata.
  - Next state:
    - ERR if misaligned (half with addr[0]=1; word with addr[1:0]!=0) or data_w is an invalid code.
    - else WR for a word store.
    - else RMW_RD for a byte or half store.
    - else RD for a load.
  - Requests are sampled only in IDLE.
- WR:
  - ram_ce=1, ram_we=1, ram_wdata=latched wdata, ack=1.
  - Next state IDLE. Store latency: ack 1 cycle after acceptance.
- RD:
  - ram_ce=1, ram_we=0.
  - Next state RDCAP.
- RDCAP:
  - Extract the lane from ram_rdata and extend it, then register the result into rdata with ack=1.
  - Next state IDLE. Load latency: ack 2 cycles after acceptance.
- RMW_RD:
  - SRAM read of the target word.
  - Next state RMW_WR.
- RMW_WR:
  - Merge into ram_rdata: wdata[7:0] into lane addr[1:0], or wdata[15:0] into half addr[1].
  - Other bytes are preserved. Write with ram_ce=1, ram_we=1, ack=1.
  - Next state IDLE. Latency: 2 cycles.
- ERR:
  - ack=1, err=1, no SRAM access, rdata unchanged.
  - Next state IDLE.
- Lanes are little-endian: addr[1:0]=0 maps to bits 7:0, addr[1:0]=3 maps to bits 31:24; addr[1]=1 maps to bits 31:16.
- Extension: byte → 24 copies of bit 7 when signed, else zeros; half → 16 copies of bit 15 when signed, else zeros; word → passthrough.
- Ordering and stalls:
  - The cycle after ack the FSM is back in IDLE, so a held or new request is accepted then.
  - ack never asserts on two consecutive cycles.
  - req_ena dropping while busy is ignored; the in-flight access completes.
- data_sign is ignored on stores. err=0 on every ack except an ERR ack.

Test Plan:
- Word store then load: store addr 0x010 data 0xDEADBEEF → ram_we pulse at word 0x004, ack at T+1. Load word from 0x010 → ack at T+2 with rdata=0xDEADBEEF, err=0.
- Byte store RMW: word 0x004 holds 0x11223344; store byte 0xAA to addr 0x012 → SRAM read then write of 0x11AA3344, ack at T+2.
- Signed/unsigned byte loads: word 0x004 holds 0x11AA3344.
  - Load byte addr 0x012 signed → rdata=0xFFFFFFAA.
  - Same load unsigned → rdata=0x000000AA.
  - Load half addr 0x012 signed → rdata=0x000011AA.
- Misaligned and invalid width:
  - Half load at 0x013 → ack at T+1, err=1, ram_ce never asserted, rdata unchanged.
  - Word store at 0x012 → same: err=1, no SRAM write.
  - data_w=3'b011 → same: err=1, no SRAM access.
- Back-to-back: req_ena held across 3 word loads → acks at T+2, T+5, T+8, with busy low exactly on the cycles in between.
- Reset mid-RMW: assert rst during RMW_RD of a byte store → outputs 0 immediately, no ram_we pulse, target word unchanged, next request after reset behaves normally.
